ant_noc_scheduler: RTL

- Central scheduler for the four-ant PageRank array. Each ant owns N pages; global page id = {ant_id[1:0], local[3:0]}.
- Serialises remote page-value requests: round-robin grant to one requesting ant, drive the query to the owning ant, capture its weighted reply, return it to the requester as a response.
- Also runs the end-of-sweep barrier: when all ants are waiting, release them together and count iterations.

---
 rtl/ant_noc_scheduler_if.sv | 29 ++
 rtl/ant_noc_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ant_noc_scheduler_if.sv
// Request/query/response and barrier bus between the ant array and the central scheduler.
interface ant_noc_scheduler_if #(
   parameter int NANT  = 4,
   parameter int N     = 16,
   parameter int WIDTH = 16,
   parameter int PW    = $clog2(NANT*N)
);
   logic [NANT-1:0]       req_valid;
   logic [NANT*PW-1:0]    req_page;
   logic [NANT-1:0]       query_valid;
   logic [PW-1:0]         query;
   logic [NANT*WIDTH-1:0] reply;
   logic [NANT-1:0]       resp_valid;
   logic [WIDTH+PW-1:0]   response;
   logic [NANT-1:0]       syc_out;
   logic [NANT-1:0]       syc_in;
   logic [15:0]           iter_count;
   logic                  busy;

   modport master (
      input  req_valid, req_page, reply, syc_out,
      output query_valid, query, resp_valid, response, syc_in, iter_count, busy
   );

   modport slave (
      output req_valid, req_page, reply, syc_out,
      input  query_valid, query, resp_valid, response, syc_in, iter_count, busy
   );
endinterface

// File: rtl/ant_noc_scheduler.sv
// Round-robin remote page-value scheduler and sweep barrier for the four-ant PageRank array.
// state | meaning
// IDLE  | arbitrate requests; otherwise release the barrier when all ants wait
// QUERY | owner's query strobe is out; its reply is captured at the closing edge
// RESP  | response pulse to the granted requester
module ant_noc_scheduler #(
   parameter int NANT  = 4,
   parameter int N     = 16,
   parameter int WIDTH = 16,
   parameter int PW    = $clog2(NANT*N)
) (
   input logic                clk,
   input logic                reset,
   ant_noc_scheduler_if.master bus
);
   typedef enum logic [1:0] {IDLE, QUERY, RESP} state_t;

   state_t              state, state_nxt;
   logic [1:0]          rr_ptr, rr_nxt;
   logic [1:0]          gnt, gnt_nxt, gnt_c, idx;
   logic                found;
   logic [PW-1:0]       pg, pg_nxt, pg_c;
   logic [1:0]          owner, owner_c;
   logic                armed, armed_nxt;
   logic [15:0]         iter, iter_nxt;
   logic [NANT-1:0]     qv, qv_nxt, rv, rv_nxt, syc, syc_nxt;
   logic [PW-1:0]       query_r, query_nxt;
   logic [WIDTH+PW-1:0] resp_r, resp_nxt;

   always_comb begin
      found = 1'b0;
      gnt_c = rr_ptr;
      idx   = '0;
      for (int i = 0; i < NANT; i++) begin
         idx = rr_ptr + 2'(i);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            gnt_c = idx;
         end
      end
   end

   assign pg_c    = bus.req_page[int'(gnt_c)*PW +: PW];
   assign owner_c = pg_c[PW-1 -: 2];
   assign owner   = pg[PW-1 -: 2];

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      gnt_nxt   = gnt;
      pg_nxt    = pg;
      armed_nxt = armed;
      iter_nxt  = iter;
      qv_nxt    = '0;
      rv_nxt    = '0;
      syc_nxt   = '0;
      query_nxt = '0;
      resp_nxt  = '0;
      if (!(&bus.syc_out))
         armed_nxt = 1'b1;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_nxt      = QUERY;
               gnt_nxt        = gnt_c;
               pg_nxt         = pg_c;
               rr_nxt         = gnt_c + 2'd1;
               qv_nxt[owner_c] = 1'b1;
               query_nxt      = pg_c;
            end else if ((&bus.syc_out) && armed) begin
               syc_nxt   = '1;
               armed_nxt = 1'b0;
               iter_nxt  = iter + 16'd1;
            end
         end
         QUERY: begin
            state_nxt   = RESP;
            rv_nxt[gnt] = 1'b1;
            resp_nxt    = {bus.reply[int'(owner)*WIDTH +: WIDTH], pg};
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         gnt     <= '0;
         pg      <= '0;
         armed   <= 1'b1;
         iter    <= '0;
         qv      <= '0;
         rv      <= '0;
         syc     <= '0;
         query_r <= '0;
         resp_r  <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_nxt;
         gnt     <= gnt_nxt;
         pg      <= pg_nxt;
         armed   <= armed_nxt;
         iter    <= iter_nxt;
         qv      <= qv_nxt;
         rv      <= rv_nxt;
         syc     <= syc_nxt;
         query_r <= query_nxt;
         resp_r  <= resp_nxt;
      end
   end

   assign bus.query_valid = qv;
   assign bus.query       = query_r;
   assign bus.resp_valid  = rv;
   assign bus.response    = resp_r;
   assign bus.syc_in      = syc;
   assign bus.iter_count  = iter;
   assign bus.busy        = (state != IDLE);
endmodule
